seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for the board's N-digit display. It is the next generation of the team's fixed 8-digit scanner. Additions over that scanner:
- configurable digit count and refresh rate
- per-digit decimal point and blanking
- leading-zero suppression
- PWM brightness
- a ghost-guard interval between digits
- a tear-free load handshake that commits new values only at frame boundaries

It sits between CPU/debug datapath registers and the board anode/cathode pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
REFRESH_DIV, 100000, clock cycles per digit slot (>= 4)
GUARD_CYCLES, 1000, cycles at slot start with all anodes off (< REFRESH_DIV)
DIM_BITS, 3, brightness resolution in bits (1..8)
ANODE_ACTIVE_LOW, 1, 1 = anode asserted low
SEG_ACTIVE_LOW, 1, 1 = segment and dp asserted low

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
data_in  in  4*NUM_DIGITS  hex nibbles; digit i = data_in[4i+3:4i]; digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_in  in  NUM_DIGITS  1 = digit dark
load  in  1  single-cycle strobe; capture data_in/dp_in/blank_in
lz_suppress  in  1  1 = blank leading zero digits
brightness  in  DIM_BITS  duty select; duty = (brightness+1)/2^DIM_BITS
anode  out  NUM_DIGITS  digit enables, one-hot when lit
cathode  out  8  {dp,g,f,e,d,c,b,a}
digit_idx  out  $clog2(NUM_DIGITS)  digit currently scanned
frame_done  out  1  one-cycle pulse at frame wrap

Behaviour:
- Reset (reset=0, asynchronous) clears everything immediately, including mid-frame:
  - slot_cnt=0, pwm_cnt=0, digit_idx=0, frame_done=0
  - pending=0, shadow and active data/dp=0, shadow and active blank=all ones
  - anode and cathode all deasserted: all ones when the polarity parameter is 1
  - Display stays dark until the first committed load.
- slot_cnt counts 0..REFRESH_DIV-1 and wraps.
  - At slot_cnt==REFRESH_DIV-1, digit_idx increments, wrapping from NUM_DIGITS-1 to 0.
  - frame_done=1 for exactly the cycle after digit_idx wraps to 0.
- pwm_cnt is a free-running DIM_BITS counter that increments every clock.
- Load handshake:
  - load=1 captures the inputs into the shadow registers and sets pending=1.
  - At the wrap cycle (slot_cnt==REFRESH_DIV-1 and digit_idx==NUM_DIGITS-1), the shadow is copied to active and pending clears.
  - If load coincides with the wrap cycle, data_in goes directly to active and pending stays 0.
  - Back-to-back loads within a frame: the last one wins.
- Leading-zero suppression (lz_suppress=1):
  - Scanning from digit NUM_DIGITS-1 downward, every digit whose active nibble is 0 is blanked until the first non-zero nibble.
  - Digit 0 is never suppressed; an all-zero value shows "0".
  - dp of a suppressed digit is still shown.
  - Explicitly blanked digits (blank=1) count as zero for suppression purposes.
- Anode:
  - Digit digit_idx is enabled only when slot_cnt >= GUARD_CYCLES, blank(eff)=0, and pwm_cnt <= brightness.
  - Otherwise no anode is asserted; never more than one.
- Cathode: hex-to-segment pattern of the active nibble (a=bit0) — 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71 — with dp in bit7, inverted if SEG_ACTIVE_LOW.
- anode and cathode are registered: one clock latency from slot_cnt/pwm_cnt/digit_idx.
- brightness and lz_suppress are sampled live (no frame commit).
- Brightness extremes: brightness=0 gives a 1/2^DIM_BITS duty; the all-ones value gives 100% duty after the guard interval.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry SEG_HEX constant table
  - function hex_to_seg(nibble) returning 7 bits
  - localparam helper for the digit index width
- Sub-module seg7_decode: a combinational nibble+dp to 8-bit cathode pattern, with a polarity parameter. It is reused by other display blocks.
- Scanner, PWM, load/commit and leading-zero logic stay in seg7_scan_ctrl.

Test Plan:
Use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, DIM_BITS=2, active-low.
1. Reset release, no load -> anode=4'hF and cathode=8'hFF for 3 full frames; frame_done pulses every 32 cycles; digit_idx sequence 0,1,2,3,0.
2. Load data_in=16'h12AF, brightness=3, lz_suppress=0 -> first commit at the next frame wrap. Digit 0:
   - slot cycles 0-1: anode=4'hF
   - slot cycles 2-7: anode=4'hE, cathode=~8'h71
   - Digit 3 shows ~8'h06.
3. Load at mid-frame, then a second load 5 cycles later -> display unchanged until wrap, then shows the second value only; a load on the exact wrap cycle commits with no extra frame delay.
4. data_in=16'h0050, lz_suppress=1 -> digits 3 and 2 dark, digit 1=~8'h6D, digit 0=~8'h3F. data_in=16'h0000 -> only digit 0 lit showing 0.
5. brightness=0 -> anode asserted for 1 of every 4 cycles after the guard (dp_in=4'h1 shows cathode bit7=0 on digit 0 only). blank_in=4'b0100 -> digit 2 never asserted.
6. Assert reset mid-slot during digit 2 with pending=1 -> outputs dark within the same cycle (asynchronous); after release, counters restart from 0 and the pending load is discarded.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex glyph table, lookup helper and
// the digit index width helper used by the scanning display blocks.
package seg7_pkg;

  // Active-high glyphs {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

  function automatic int digit_idx_w(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble + decimal point to 8-bit cathode pattern {dp,g,f,e,d,c,b,a}.
// blank turns the glyph segments off while leaving dp under control.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] cathode
);

  logic [7:0] pat;

  always_comb begin
    pat     = {dp, blank ? 7'h00 : hex_to_seg(nibble)};
    cathode = ACTIVE_LOW ? ~pat : pat;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with PWM dimming, ghost guard,
// leading-zero suppression and frame-boundary commit of loaded values.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 8,
  parameter int REFRESH_DIV      = 100000,
  parameter int GUARD_CYCLES     = 1000,
  parameter int DIM_BITS         = 3,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [4*NUM_DIGITS-1:0]               data_in,
  input  logic [NUM_DIGITS-1:0]                 dp_in,
  input  logic [NUM_DIGITS-1:0]                 blank_in,
  input  logic                                  load,
  input  logic                                  lz_suppress,
  input  logic [DIM_BITS-1:0]                   brightness,
  output logic [NUM_DIGITS-1:0]                 anode,
  output logic [7:0]                            cathode,
  output logic [digit_idx_w(NUM_DIGITS)-1:0]    digit_idx,
  output logic                                  frame_done
);

  localparam int IW = digit_idx_w(NUM_DIGITS);
  localparam int SW = $clog2(REFRESH_DIV);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};

  logic [SW-1:0]           slot_cnt;
  logic [DIM_BITS-1:0]     pwm_cnt;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] sh_data, act_data;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp, sh_blank, act_blank;

  logic                    slot_end, frame_end;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    lead;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank, cur_supp, lit;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [7:0]              dec_cathode;

  assign slot_end  = (slot_cnt == SW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (digit_idx == IW'(NUM_DIGITS - 1));

  // Walk down from the top digit; explicitly blanked digits count as zero.
  always_comb begin
    lead = 1'b1;
    supp = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead    = lead && (act_blank[i] || (act_data[4*i +: 4] == 4'h0));
      supp[i] = lead && lz_suppress;
    end
  end

  always_comb begin
    cur_nib   = act_data[4*digit_idx +: 4];
    cur_dp    = act_dp[digit_idx];
    cur_blank = act_blank[digit_idx];
    cur_supp  = supp[digit_idx];
    // A suppressed digit stays lit only to show its decimal point.
    lit       = (slot_cnt >= SW'(GUARD_CYCLES)) && !cur_blank &&
                !(cur_supp && !cur_dp) && (pwm_cnt <= brightness);
    onehot    = lit ? (NUM_DIGITS'(1) << digit_idx) : '0;
  end

  seg7_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
    .nibble  (cur_nib),
    .dp      (cur_dp),
    .blank   (cur_supp),
    .cathode (dec_cathode)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt   <= '0;
      pwm_cnt    <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
      pending    <= 1'b0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_blank   <= '1;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      anode      <= AN_OFF;
      cathode    <= SEG_OFF;
    end else begin
      pwm_cnt    <= pwm_cnt + DIM_BITS'(1);
      slot_cnt   <= slot_end ? '0 : slot_cnt + SW'(1);
      frame_done <= frame_end;
      if (slot_end)
        digit_idx <= frame_end ? '0 : digit_idx + IW'(1);

      if (frame_end) begin
        pending <= 1'b0;
        if (load) begin
          // Load on the wrap cycle bypasses the shadow entirely.
          act_data  <= data_in;
          act_dp    <= dp_in;
          act_blank <= blank_in;
          sh_data   <= data_in;
          sh_dp     <= dp_in;
          sh_blank  <= blank_in;
        end else if (pending) begin
          act_data  <= sh_data;
          act_dp    <= sh_dp;
          act_blank <= sh_blank;
        end
      end else if (load) begin
        sh_data  <= data_in;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
        pending  <= 1'b1;
      end

      anode   <= ANODE_ACTIVE_LOW ? ~onehot : onehot;
      cathode <= lit ? dec_cathode : SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 8-cycle slots, 2-cycle guard,
// 2-bit dimming, active-low pins. t counts clock edges since reset release.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic        lz_suppress = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic [3:0]  anode;
  logic [7:0]  cathode;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int t = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2), .DIM_BITS(2),
    .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .lz_suppress(lz_suppress),
    .brightness(brightness), .anode(anode), .cathode(cathode),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s t=%0d: got %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an, input logic [7:0] cat);
    chk({tag, ".anode"}, {4'h0, anode}, {4'h0, an});
    chk({tag, ".cathode"}, cathode, cat);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, ".anode"}, {4'h0, anode}, 8'h0F);
  endtask

  task automatic chk_scan(input string tag);
    chk({tag, ".didx"}, {6'h0, digit_idx}, 8'((t / 8) % 4));
    chk({tag, ".fdone"}, {7'h0, frame_done}, {7'h0, (t % 32 == 0) && (t > 0)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic adv_to(input int p);
    while (t % 32 != p) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data_in  = d;
    dp_in    = dp;
    blank_in = bl;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    // Reset held over several edges, released away from the edge.
    repeat (3) @(posedge clk);
    #1;
    chk_out("in_reset", 4'hF, 8'hFF);
    #2;
    reset = 1'b1;
    t = 0;
    chk_out("rst_rel", 4'hF, 8'hFF);
    chk_scan("rst_rel");

    // 1: three dark frames, scan sequence and frame pulse
    for (int i = 0; i < 96; i++) begin
      tick();
      chk_out("idle", 4'hF, 8'hFF);
      chk_scan("idle");
    end

    // 2: load 12AF, committed at the next wrap (t=128)
    adv_to(3);
    do_load(16'h12AF, 4'h0, 4'h0);
    chk_dark("pre_commit_a");
    adv_to(31);
    chk_dark("pre_commit_b");
    tick();
    tick();
    chk_dark("d0_guard0");
    tick();
    chk_dark("d0_guard1");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("d0_lit", 4'hE, 8'h8E);
    end
    tick();
    chk_dark("d1_guard0");
    adv_to(11);
    chk_out("d1_A", 4'hD, 8'h88);
    adv_to(19);
    chk_out("d2_2", 4'hB, 8'hA4);
    adv_to(27);
    chk_out("d3_1", 4'h7, 8'hF9);
    chk_scan("d3_1");

    // 3: two loads in one frame, last one wins at the wrap
    adv_to(5);
    do_load(16'h3333, 4'h0, 4'h0);
    repeat (4) tick();
    do_load(16'h4567, 4'h0, 4'h0);
    chk_out("hold_d1", 4'hD, 8'h88);
    adv_to(27);
    chk_out("hold_d3", 4'h7, 8'hF9);
    adv_to(3);
    chk_out("second_d0", 4'hE, 8'hF8);
    adv_to(27);
    chk_out("second_d3", 4'h7, 8'h99);
    // load exactly on the wrap cycle commits immediately
    adv_to(31);
    do_load(16'h89AB, 4'h0, 4'h0);
    adv_to(3);
    chk_out("wrap_d0", 4'hE, 8'h83);
    adv_to(11);
    chk_out("wrap_d1", 4'hD, 8'h88);
    adv_to(19);
    chk_out("wrap_d2", 4'hB, 8'h90);

    // 4: leading-zero suppression
    adv_to(20);
    lz_suppress = 1'b1;
    do_load(16'h0050, 4'h0, 4'h0);
    adv_to(3);
    chk_out("lz_d0", 4'hE, 8'hC0);
    adv_to(11);
    chk_out("lz_d1", 4'hD, 8'h92);
    adv_to(19);
    chk_dark("lz_d2");
    adv_to(27);
    chk_dark("lz_d3");
    adv_to(28);
    do_load(16'h0000, 4'h0, 4'h0);
    adv_to(3);
    chk_out("lz0_d0", 4'hE, 8'hC0);
    adv_to(11);
    chk_dark("lz0_d1");
    adv_to(19);
    chk_dark("lz0_d2");
    adv_to(27);
    chk_dark("lz0_d3");

    // 5: minimum brightness, dp on digit 0, digit 2 blanked
    adv_to(28);
    lz_suppress = 1'b0;
    brightness  = 2'd0;
    do_load(16'h1234, 4'h1, 4'b0100);
    adv_to(3);
    chk_dark("dim_s2");
    tick();
    chk_dark("dim_s3");
    tick();
    chk_out("dim_s4", 4'hE, 8'h19);
    tick();
    chk_dark("dim_s5");
    tick();
    chk_dark("dim_s6");
    tick();
    chk_dark("dim_s7");
    adv_to(13);
    chk_out("dim_d1", 4'hD, 8'hB0);
    for (int i = 0; i < 8; i++) begin
      adv_to(17 + i);
      chk_dark("blank_d2");
    end
    adv_to(29);
    chk_out("dim_d3", 4'h7, 8'hF9);

    // 6: asynchronous reset mid-slot on digit 2 with a load pending
    adv_to(30);
    brightness = 2'd3;
    do_load(16'h1234, 4'h0, 4'h0);
    adv_to(17);
    do_load(16'hFFFF, 4'h0, 4'h0);
    adv_to(20);
    chk_out("pre_rst_d2", 4'hB, 8'hA4);
    #2;
    reset = 1'b0;
    #1;
    chk_out("async_rst", 4'hF, 8'hFF);
    chk("async_didx", {6'h0, digit_idx}, 8'h00);
    chk("async_fdone", {7'h0, frame_done}, 8'h00);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    t = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      chk_out("post_rst", 4'hF, 8'hFF);
      chk_scan("post_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
